line_fill_arbiter: RTL
======================

Name: line_fill_arbiter

Overview:
Shares the single memory read port among the per-core instruction/data caches for whole-line refills. Accepts one line-fill request per core and grants one at a time, round-robin. Issues WORDS_PER_LINE sequential word reads to memory and streams the returned words, tagged with word index, back to the granted core. Sits between the per-core cache controllers and the shared memory interface.

Parameters:
NUM_CORES, 4, number of requesting cores (>=2)
ADDR_W, 32, byte address width
DATA_SIZE, 32, word width (package constant)
WORDS_PER_LINE, 8, words per line (package constant); WORD_BITS and LINE_SIZE derived from package

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
core_req  in  NUM_CORES  per-core fill request level; held until matching core_done
core_addr  in  NUM_CORES*ADDR_W  per-core miss address, core i in bits [i*ADDR_W +: ADDR_W]
core_grant  out  NUM_CORES  one-hot, high for the whole fill of the owning core
core_rvalid  out  NUM_CORES  one-hot beat valid to owning core
core_rdata  out  DATA_SIZE  beat data, shared bus
core_widx  out  WORD_BITS  word index within line of current beat
core_done  out  NUM_CORES  one-cycle pulse coincident with last beat
mem_req_valid  out  1  memory read request valid
mem_req_ready  in  1  memory accepts request when valid&ready
mem_addr  out  ADDR_W  word-aligned read address
mem_rsp_valid  in  1  in-order read response valid (no backpressure)
mem_rsp_data  in  DATA_SIZE  read response data

Behaviour:
- Reset, synchronous on rst high at clk edge: state IDLE, all outputs 0, rr pointer 0, counters 0. Reset mid-fill abandons the fill, no core_done; memory side must be reset in the same cycle, and responses arriving after reset are ignored in IDLE.
- FSM states: IDLE, FILL.
- IDLE: if any core_req, pick first requester searching ptr, ptr+1, ... mod NUM_CORES. Register grant one-hot, base = core_addr aligned down to LINE_SIZE (low $clog2(LINE_SIZE) bits cleared), issue_cnt=0, rsp_cnt=0; go FILL next cycle. No request -> stay IDLE. Grant visible one cycle after core_req is sampled.
- FILL issue: mem_req_valid=1 while issue_cnt<WORDS_PER_LINE; mem_addr = base + issue_cnt*(DATA_SIZE/8). On valid&ready, issue_cnt++. mem_addr/valid stable while ready low. After WORDS_PER_LINE accepts, mem_req_valid=0.
- FILL response: on mem_rsp_valid, register to outputs next cycle: core_rvalid[g]=1, core_rdata=mem_rsp_data, core_widx=rsp_cnt; rsp_cnt++. Responses may overlap issue. Fixed one-cycle response latency.
- Last beat (rsp_cnt==WORDS_PER_LINE-1): core_done[g] pulses with that beat; next cycle grant clears, ptr=g+1 mod NUM_CORES, state IDLE. Minimum one IDLE cycle between fills.
- core_req dropped mid-fill: fill still completes, done still pulses.
- mem_rsp_valid in IDLE or beyond WORDS_PER_LINE responses: ignored.
- core_rvalid/core_done never high for non-granted core; core_grant at most one-hot.
- Width: counters WORD_BITS+1 bits; address add wraps modulo 2^ADDR_W (cannot cross line since base aligned).

Decomposition:
- multicore_pkg gains: NUM_CORES constant, t_fill_state enum (IDLE, FILL), LINE_OFFSET_BITS = $clog2(LINE_SIZE).
- One sub-module: rr_arbiter (NUM_CORES-wide combinational priority search from pointer, one-hot out); pointer register and FSM stay in line_fill_arbiter.

Test Plan:
- Single fill: core 2 req, addr 0x0000_1234, mem_req_ready=1, responses 0xA0..0xA7 one per cycle -> grant=0b0100, mem_addr 0x1220,0x1224,...,0x123C; core_rvalid[2] beats widx 0..7 with data 0xA0..0xA7; core_done[2] on widx 7.
- All four request together from reset -> grants in order core 0,1,2,3, each full 8 beats, no overlap of grants.
- Fairness: core 1 just finished (ptr=2), cores 0 and 1 requesting -> core 0 granted next, then core 1.
- Backpressure: mem_req_ready low 3 cycles on 4th request -> mem_addr holds base+0xC, no skipped or duplicated address, 8 beats total.
- Reset mid-fill after 3 beats, then stray mem_rsp_valid -> all outputs 0, no core_done, stray response ignored; next request fills normally with ptr=0.
- Stray mem_rsp_valid in IDLE with no requests -> no core_rvalid, state stays IDLE.

Source files
------------

// File: rtl/line_fill_arbiter_pkg.sv
// Shared constants and types for the line-fill arbiter.
// Holds the cache geometry (word width, words per line, derived line size and
// offset widths), the default core count and the fill FSM state encoding.
package line_fill_arbiter_pkg;

   localparam int NUM_CORES        = 4;
   localparam int DATA_SIZE        = 32;
   localparam int WORDS_PER_LINE   = 8;
   localparam int WORD_BITS        = $clog2(WORDS_PER_LINE);
   localparam int BYTES_PER_WORD   = DATA_SIZE / 8;
   localparam int LINE_SIZE        = WORDS_PER_LINE * BYTES_PER_WORD;
   localparam int LINE_OFFSET_BITS = $clog2(LINE_SIZE);

   // Counters carry one extra bit so "all words done" is representable.
   localparam int CNT_W = WORD_BITS + 1;
   localparam logic [CNT_W-1:0] LINE_WORDS_CNT = CNT_W'(WORDS_PER_LINE);
   localparam logic [CNT_W-1:0] LAST_WORD_CNT  = CNT_W'(WORDS_PER_LINE - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } t_fill_state;

endpackage

// File: rtl/line_fill_arbiter_if.sv
// Bundle of the per-core refill signals and the shared memory read port.
// Ports (arbiter view, modport master):
//   in : core_req, core_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data
//   out: core_grant, core_rvalid, core_rdata, core_widx, core_done,
//        mem_req_valid, mem_addr
// The slave modport is the mirror image used by the cores/memory side.
interface line_fill_arbiter_if
   import line_fill_arbiter_pkg::*;
#(
   parameter int NUM_CORES = line_fill_arbiter_pkg::NUM_CORES,
   parameter int ADDR_W    = 32
) ();

   logic [NUM_CORES-1:0]        core_req;
   logic [NUM_CORES*ADDR_W-1:0] core_addr;
   logic [NUM_CORES-1:0]        core_grant;
   logic [NUM_CORES-1:0]        core_rvalid;
   logic [DATA_SIZE-1:0]        core_rdata;
   logic [WORD_BITS-1:0]        core_widx;
   logic [NUM_CORES-1:0]        core_done;
   logic                        mem_req_valid;
   logic                        mem_req_ready;
   logic [ADDR_W-1:0]           mem_addr;
   logic                        mem_rsp_valid;
   logic [DATA_SIZE-1:0]        mem_rsp_data;

   modport master (
      input  core_req, core_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output core_grant, core_rvalid, core_rdata, core_widx, core_done,
             mem_req_valid, mem_addr
   );

   modport slave (
      output core_req, core_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  core_grant, core_rvalid, core_rdata, core_widx, core_done,
             mem_req_valid, mem_addr
   );

endinterface

// File: rtl/line_fill_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches req starting at ptr, wrapping
// modulo NUM_CORES, and returns the first requester as one-hot plus index.
// Ports:
//   req         in  NUM_CORES  request levels
//   ptr         in  IDX_W      highest-priority index for this search
//   grant       out NUM_CORES  one-hot winner (zero when no request)
//   grant_idx   out IDX_W      binary index of the winner
//   grant_valid out 1          any request present
module rr_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_CORES-1:0] grant,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 grant_valid
);

   logic [IDX_W:0]   sum_s;
   logic [IDX_W-1:0] cand_s;

   // Priority search from ptr; first hit wins, later hits are masked.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      sum_s       = '0;
      cand_s      = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         sum_s = {1'b0, ptr} + (IDX_W+1)'(i);
         if (sum_s >= (IDX_W+1)'(NUM_CORES)) begin
            sum_s = sum_s - (IDX_W+1)'(NUM_CORES);
         end else begin
            sum_s = sum_s;
         end
         cand_s = sum_s[IDX_W-1:0];
         if (!grant_valid && req[cand_s]) begin
            grant_valid    = 1'b1;
            grant[cand_s]  = 1'b1;
            grant_idx      = cand_s;
         end else begin
            grant_valid = grant_valid;
         end
      end
   end

endmodule

// File: rtl/line_fill_arbiter.sv
// Shares the single memory read port among per-core caches for line refills.
// One core is granted at a time (round-robin); the arbiter issues
// WORDS_PER_LINE sequential word reads and streams the in-order responses
// back to the owner, tagged with their word index.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  master modport of line_fill_arbiter_if (core side + memory side)
module line_fill_arbiter
   import line_fill_arbiter_pkg::*;
#(
   parameter int NUM_CORES = line_fill_arbiter_pkg::NUM_CORES,
   parameter int ADDR_W    = 32
) (
   input logic                 clk,
   input logic                 rst,
   line_fill_arbiter_if.master bus
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_SIZE - 1);
   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(BYTES_PER_WORD);

   t_fill_state          state_r;
   logic [IDX_W-1:0]     ptr_r;
   logic [IDX_W-1:0]     grant_idx_r;
   logic [NUM_CORES-1:0] grant_r;
   logic [NUM_CORES-1:0] rvalid_r;
   logic [NUM_CORES-1:0] done_r;
   logic [DATA_SIZE-1:0] rdata_r;
   logic [WORD_BITS-1:0] widx_r;
   logic                 mem_req_valid_r;
   logic [ADDR_W-1:0]    mem_addr_r;
   logic [CNT_W-1:0]     issue_cnt_r;
   logic [CNT_W-1:0]     rsp_cnt_r;

   logic [NUM_CORES-1:0] pick_oh_s;
   logic [IDX_W-1:0]     pick_idx_s;
   logic                 pick_valid_s;
   logic [ADDR_W-1:0]    sel_addr_s;
   logic [ADDR_W-1:0]    line_base_s;
   logic [IDX_W-1:0]     next_ptr_s;

   rr_arbiter #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_rr_arbiter (
      .req         (bus.core_req),
      .ptr         (ptr_r),
      .grant       (pick_oh_s),
      .grant_idx   (pick_idx_s),
      .grant_valid (pick_valid_s)
   );

   // Miss address of the core picked this cycle, aligned down to its line.
   always_comb begin
      sel_addr_s = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (pick_oh_s[i]) begin
            sel_addr_s = bus.core_addr[i*ADDR_W +: ADDR_W];
         end else begin
            sel_addr_s = sel_addr_s;
         end
      end
      line_base_s = sel_addr_s & ~LINE_MASK;
   end

   // Pointer advances to the core after the one whose fill just completed.
   always_comb begin
      if (grant_idx_r == IDX_W'(NUM_CORES - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_idx_r + IDX_W'(1);
      end
   end

   // Fill FSM: grant, request issue, response streaming and release.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= IDLE;
         ptr_r           <= '0;
         grant_idx_r     <= '0;
         grant_r         <= '0;
         rvalid_r        <= '0;
         done_r          <= '0;
         rdata_r         <= '0;
         widx_r          <= '0;
         mem_req_valid_r <= 1'b0;
         mem_addr_r      <= '0;
         issue_cnt_r     <= '0;
         rsp_cnt_r       <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               // Responses seen here are stale and deliberately dropped.
               rvalid_r <= '0;
               done_r   <= '0;
               if (pick_valid_s) begin
                  state_r         <= FILL;
                  grant_r         <= pick_oh_s;
                  grant_idx_r     <= pick_idx_s;
                  mem_addr_r      <= line_base_s;
                  mem_req_valid_r <= 1'b1;
                  issue_cnt_r     <= '0;
                  rsp_cnt_r       <= '0;
               end else begin
                  state_r <= IDLE;
               end
            end
            FILL: begin
               if (done_r != '0) begin
                  // Last beat was presented last cycle: release the owner.
                  state_r  <= IDLE;
                  grant_r  <= '0;
                  rvalid_r <= '0;
                  done_r   <= '0;
                  ptr_r    <= next_ptr_s;
               end else begin
                  // Address and valid hold until the memory accepts.
                  if (mem_req_valid_r && bus.mem_req_ready) begin
                     issue_cnt_r <= issue_cnt_r + CNT_W'(1);
                     if (issue_cnt_r == LAST_WORD_CNT) begin
                        mem_req_valid_r <= 1'b0;
                     end else begin
                        mem_addr_r <= mem_addr_r + WORD_STEP;
                     end
                  end else begin
                     issue_cnt_r <= issue_cnt_r;
                  end
                  // Responses beyond a full line are ignored.
                  if (bus.mem_rsp_valid && (rsp_cnt_r < LINE_WORDS_CNT)) begin
                     rvalid_r  <= grant_r;
                     rdata_r   <= bus.mem_rsp_data;
                     widx_r    <= rsp_cnt_r[WORD_BITS-1:0];
                     rsp_cnt_r <= rsp_cnt_r + CNT_W'(1);
                     done_r    <= (rsp_cnt_r == LAST_WORD_CNT) ? grant_r : '0;
                  end else begin
                     rvalid_r <= '0;
                     done_r   <= '0;
                  end
               end
            end
            default: begin
               state_r         <= IDLE;
               grant_r         <= '0;
               rvalid_r        <= '0;
               done_r          <= '0;
               mem_req_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.core_grant    = grant_r;
   assign bus.core_rvalid   = rvalid_r;
   assign bus.core_rdata    = rdata_r;
   assign bus.core_widx     = widx_r;
   assign bus.core_done     = done_r;
   assign bus.mem_req_valid = mem_req_valid_r;
   assign bus.mem_addr      = mem_addr_r;

endmodule
